// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one SRAM-style request at
// a time, buffers a single fetched instruction for decode, and discards
// in-flight or buffered instructions when a redirect arrives.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] jrpc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_pc, pend_pc_next;
  logic        cancel, cancel_next;
  logic        if_valid_next;
  logic [31:0] if_pc_next, if_inst_next;
  logic        redirect;
  logic [31:0] target;

  // Redirect decode: pcsource 00 means no redirect even with br_valid high.
  always_comb begin
    redirect = br_valid && (pcsource != 2'b00);
    case (pcsource)
      2'b01:   target = jrpc;
      2'b10:   target = jpc;
      2'b11:   target = bpc;
      default: target = fetch_pc;
    endcase
  end

  // Next-state and next-register logic for the REQ/WAIT/HOLD sequencer.
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    pend_valid_next = pend_valid;
    pend_pc_next    = pend_pc;
    cancel_next     = cancel;
    if_valid_next   = if_valid;
    if_pc_next      = if_pc;
    if_inst_next    = if_inst;
    case (state)
      S_REQ: begin
        // The request address must stay stable, so a redirect is only recorded.
        if (redirect) begin
          pend_valid_next = 1'b1;
          pend_pc_next    = target;
        end
        if (inst_addr_ok) begin
          state_next  = S_WAIT;
          cancel_next = pend_valid || redirect;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (cancel || redirect) begin
            cancel_next     = 1'b0;
            fetch_pc_next   = redirect ? target : pend_pc;
            pend_valid_next = 1'b0;
            state_next      = S_REQ;
          end else begin
            if_valid_next = 1'b1;
            if_pc_next    = fetch_pc;
            if_inst_next  = inst_rdata;
            state_next    = S_HOLD;
          end
        end else if (redirect) begin
          cancel_next     = 1'b1;
          pend_valid_next = 1'b1;
          pend_pc_next    = target;
        end
      end
      S_HOLD: begin
        // A same-cycle id_allowin still delivers; the redirect then kills the rest.
        if (redirect) begin
          if_valid_next   = 1'b0;
          fetch_pc_next   = target;
          pend_valid_next = 1'b0;
          state_next      = S_REQ;
        end else if (id_allowin) begin
          if_valid_next = 1'b0;
          fetch_pc_next = if_pc + 32'd4;
          state_next    = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  // State and datapath registers; reset aborts any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
      cancel     <= 1'b0;
      if_valid   <= 1'b0;
      if_pc      <= RESET_PC;
      if_inst    <= 32'd0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      pend_valid <= pend_valid_next;
      pend_pc    <= pend_pc_next;
      cancel     <= cancel_next;
      if_valid   <= if_valid_next;
      if_pc      <= if_pc_next;
      if_inst    <= if_inst_next;
    end
  end

  // Request is suppressed while reset is held so nothing is issued mid-reset.
  always_comb begin
    inst_req  = (state == S_REQ) && !rst;
    inst_addr = fetch_pc;
    if_pc4    = if_pc + 32'd4;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that owns the PC register and sequences the instruction-fetch stage against an SRAM-like instruction memory with address/data handshakes. It selects the next fetch address from the sequential path or from a redirect target (branch, jump, jump-register) using the stage's 2-bit `pcsource` encoding. It keeps at most one memory request outstanding, buffers one fetched instruction while decode is stalled, and discards in-flight or buffered instructions on redirect.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `br_valid` input 1: redirect request this cycle.
- `pcsource` input 2: target select, qualified by `br_valid`.
  - 00: none.
  - 01: `jrpc`.
  - 10: `jpc`.
  - 11: `bpc`.
- `bpc`, `jpc`, `jrpc` input 32 each: redirect targets.
- `inst_req` output 1: memory request valid.
- `inst_addr` output 32: request address.
- `inst_addr_ok` input 1: request accepted this cycle.
- `inst_data_ok` input 1: read data valid this cycle.
- `inst_rdata` input 32: read data.
- `id_allowin` input 1: decode accepts an instruction this cycle.
- `if_valid` output 1: buffered instruction valid to decode.
- `if_pc` output 32: PC of buffered instruction.
- `if_inst` output 32: buffered instruction.
- `if_pc4` output 32: `if_pc + 4`, combinational, modulo 2^32.

## Operation
- Internal registers:
  - `fetch_pc`: address of current/next request.
  - `pend_valid`/`pend_pc`: latched redirect target.
  - `cancel`: accepted request whose data must be dropped.
  - Output buffer: `if_valid`, `if_pc`, `if_inst`.
- Redirect is taken when `br_valid=1` and `pcsource!=00`. Target is selected per `pcsource`. `br_valid` with `pcsource=00` is ignored.
- A redirect kills every instruction not delivered in that same cycle. Delivery means `if_valid && id_allowin`. Decode raises `br_valid` only after the delay-slot instruction has been delivered.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - `inst_req=1`, `inst_addr=fetch_pc`. Address is held stable until `inst_addr_ok`.
  - A redirect in REQ sets `pend_valid`/`pend_pc` and does not change `inst_addr`.
  - On `inst_addr_ok`: go to WAIT. Set `cancel` if `pend_valid` or a redirect occurs in the same cycle.
- WAIT:
  - `inst_req=0`.
  - A redirect in WAIT sets `cancel` and latches `pend_pc`.
  - On `inst_data_ok` with `cancel` (including a redirect in the same cycle): drop data, clear `cancel`, `fetch_pc <= pend_pc`, clear `pend_valid`, go to REQ.
  - On `inst_data_ok` without `cancel`: load the buffer (`if_valid=1`, `if_pc=fetch_pc`, `if_inst=inst_rdata`), go to HOLD.
- HOLD:
  - `if_valid=1`, buffer frozen while `id_allowin=0`.
  - On `id_allowin=1` without redirect: `if_valid<=0`, `fetch_pc<=if_pc+4`, go to REQ.
  - On a redirect (with or without `id_allowin`): buffer still counts as delivered if `id_allowin=1`. Then `if_valid<=0`, `fetch_pc<=` target, `pend_valid` cleared, go to REQ.
- Later redirect wins: a second redirect before the pending one is consumed overwrites `pend_pc`.
- Only one request is outstanding at a time. `inst_data_ok` outside WAIT is ignored.
- The address is not checked for alignment. `fetch_pc+4` wraps modulo 2^32.

## Timing
- Reset (async, immediate):
  - State REQ, `fetch_pc=RESET_PC`, `pend_valid=0`, `cancel=0`.
  - `inst_req=0` while `rst=1`.
  - `if_valid=0`, `if_pc=RESET_PC`, `if_inst=0`, `inst_addr=RESET_PC`.
- First cycle after `rst` deasserts: `inst_req=1`, `inst_addr=RESET_PC`.
- Best-case throughput is 1 instruction per 3 cycles:
  - c0: REQ, with `addr_ok`.
  - c1: WAIT, with `data_ok`.
  - c2: HOLD, with `allowin`.
  - c3: REQ for next PC.
- `inst_data_ok` arrives no earlier than the cycle after `inst_addr_ok`.
- Each memory wait cycle adds one cycle. Each decode stall cycle adds one cycle in HOLD.
- Redirect to target request:
  - Redirect in HOLD: target on `inst_addr` next cycle.
  - Redirect in WAIT: target requested the cycle after `data_ok`.
  - Redirect in REQ: after `addr_ok`, the data return, then the target request.
- Reset mid-operation aborts any outstanding request. Data returned after reset is ignored until a new request is accepted.

## Test plan
- Reset, then zero-wait memory with `id_allowin=1`:
  - `inst_addr` sequence is BFC00000, BFC00004, BFC00008, each exactly 3 cycles apart.
  - `if_pc`/`if_inst` match; `if_pc4=BFC00004` for the first instruction.
- `id_allowin=0` for 5 cycles while in HOLD:
  - `if_valid`, `if_pc`, `if_inst` are stable and `inst_req=0` throughout.
  - Next request is issued the cycle after `id_allowin=1`.
- Redirect in WAIT (`pcsource=11`, `bpc=BFC00100`) with `data_ok` 2 cycles later:
  - Returned data is never presented (`if_valid` stays 0).
  - Next `inst_addr=BFC00100`.
- Redirect in REQ with `addr_ok` held 0 for 3 cycles (`pcsource=01`, `jrpc=BFC00200`):
  - `inst_addr` stays at the old PC until accepted.
  - That data is dropped; next request is BFC00200.
- Redirect in HOLD in the same cycle as `id_allowin=1` (`pcsource=10`, `jpc=BFC00300`):
  - Buffered instruction is delivered once.
  - Next cycle `inst_addr=BFC00300`; `br_valid` with `pcsource=00` causes no change.
- Assert `rst` while in WAIT, then return `data_ok` after reset:
  - Outputs return to reset values immediately.
  - Stale data is not buffered; the fetch restarts at `RESET_PC`.
